line_buffer_13_rows: RTL and testbench

- Producer side of the 13-row window interface.
- Accepts a raster pixel stream one pixel per strobe. Emits 13 vertically aligned row taps, S1_o (oldest row) through S13_o (newest row), plus a row-valid strobe.
- These outputs drive the S1_i..S13_i and done_i inputs of the 13x13 window buffer.
- Built from 12 chained line delays, each COLS pixels deep, with a frame position counter.

---
 rtl/line_buffer_13_rows_pkg.sv | 11 +
 rtl/line_buffer_13_rows_line_delay.sv | 27 ++
 rtl/line_buffer_13_rows.sv | 93 +++++++++
 tb/tb_line_buffer_13_rows.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/line_buffer_13_rows_pkg.sv
// rtl/line_buffer_13_rows_pkg.sv - shared constants for the 13-row line buffer
package line_buffer_13_rows_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_ROWS = 13;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer_13_rows_line_delay.sv
// rtl/line_buffer_13_rows_line_delay.sv - enable-gated pixel shift register, DEPTH stages
module line_buffer_13_rows_line_delay
    import line_buffer_13_rows_pkg::*;
#(
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/line_buffer_13_rows.sv
// rtl/line_buffer_13_rows.sv - raster stream to 13 vertically aligned row taps
module line_buffer_13_rows
    import line_buffer_13_rows_pkg::*;
#(
    parameter int COLS = 11,
    parameter int ROWS = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] data_i,
    input  logic             done_i,
    output logic [PIX_W-1:0] S1_o,
    output logic [PIX_W-1:0] S2_o,
    output logic [PIX_W-1:0] S3_o,
    output logic [PIX_W-1:0] S4_o,
    output logic [PIX_W-1:0] S5_o,
    output logic [PIX_W-1:0] S6_o,
    output logic [PIX_W-1:0] S7_o,
    output logic [PIX_W-1:0] S8_o,
    output logic [PIX_W-1:0] S9_o,
    output logic [PIX_W-1:0] S10_o,
    output logic [PIX_W-1:0] S11_o,
    output logic [PIX_W-1:0] S12_o,
    output logic [PIX_W-1:0] S13_o,
    output logic             done_o,
    output logic             frame_done_o
);

    localparam int CW = cnt_width(ROWS * COLS);
    localparam logic [CW-1:0] LAST_IDX = CW'(ROWS * COLS - 1);
    localparam logic [CW-1:0] WARM_END = CW'((WIN_ROWS - 1) * COLS);

    if (COLS < 2 || ROWS < WIN_ROWS) begin : g_bad_params
        $error("line_buffer_13_rows: requires COLS >= 2 and ROWS >= 13");
    end

    logic [CW-1:0]    cnt_q;
    logic [PIX_W-1:0] s13_q;
    logic             done_q;
    logic             frame_done_q;
    logic [PIX_W-1:0] tap [WIN_ROWS];

    wire accept    = done_i;
    wire last_pix  = (cnt_q == LAST_IDX);
    wire streaming = (cnt_q >= WARM_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            s13_q        <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            done_q       <= accept && streaming;
            frame_done_q <= accept && last_pix;
            if (accept) begin
                s13_q <= data_i;
                cnt_q <= last_pix ? '0 : cnt_q + 1'b1;
            end
        end
    end

    assign tap[WIN_ROWS-1] = s13_q;

    // Each delay is fed the previous-pixel register, so its tail is exactly COLS pixels older.
    for (genvar g = 0; g < WIN_ROWS - 1; g++) begin : g_chain
        line_buffer_13_rows_line_delay #(.DEPTH(COLS)) u_delay (
            .clk   (clk),
            .rst_n (rst),
            .en    (accept),
            .din   (tap[WIN_ROWS-1-g]),
            .dout  (tap[WIN_ROWS-2-g])
        );
    end

    assign S1_o  = tap[0];
    assign S2_o  = tap[1];
    assign S3_o  = tap[2];
    assign S4_o  = tap[3];
    assign S5_o  = tap[4];
    assign S6_o  = tap[5];
    assign S7_o  = tap[6];
    assign S8_o  = tap[7];
    assign S9_o  = tap[8];
    assign S10_o = tap[9];
    assign S11_o = tap[10];
    assign S12_o = tap[11];
    assign S13_o = tap[12];

    assign done_o       = done_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_line_buffer_13_rows.sv
// tb/tb_line_buffer_13_rows.sv - scoreboard bench for line_buffer_13_rows
module tb_line_buffer_13_rows;

    localparam int COLS  = 11;
    localparam int ROWS  = 13;
    localparam int FRAME = COLS * ROWS;

    typedef logic [12:0][7:0] taps_t;
    typedef struct packed {
        taps_t taps;
        logic  done;
        logic  fdone;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_i = '0;
    logic       done_i = 1'b0;
    logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12, s13;
    logic       done_o, frame_done_o;

    int vectors = 0;
    int miscompares = 0;

    exp_t sb[$];
    logic [7:0] hist[$];
    int nacc = 0;

    always #5 clk = ~clk;

    line_buffer_13_rows #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .done_i(done_i),
        .S1_o(s1), .S2_o(s2), .S3_o(s3), .S4_o(s4), .S5_o(s5), .S6_o(s6),
        .S7_o(s7), .S8_o(s8), .S9_o(s9), .S10_o(s10), .S11_o(s11), .S12_o(s12),
        .S13_o(s13), .done_o(done_o), .frame_done_o(frame_done_o)
    );

    function automatic exp_t dut_now();
        exp_t r;
        r.taps  = {s13, s12, s11, s10, s9, s8, s7, s6, s5, s4, s3, s2, s1};
        r.done  = done_o;
        r.fdone = frame_done_o;
        return r;
    endfunction

    // Reference: tap for S(i+1) is the pixel accepted 12-i rows (COLS pixels each) before the newest.
    function automatic taps_t model_taps();
        taps_t t;
        for (int i = 0; i < 13; i++) begin
            int idx = hist.size() - 1 - (12 - i) * COLS;
            t[i] = (idx >= 0) ? hist[idx] : 8'd0;
        end
        return t;
    endfunction

    task automatic cycle(input bit v, input logic [7:0] d);
        exp_t e;
        done_i = v;
        data_i = d;
        @(posedge clk);
        e = '0;
        if (rst) begin
            if (v) begin
                int k = nacc % FRAME;
                hist.push_back(d);
                nacc++;
                e.done  = (k >= 12 * COLS);
                e.fdone = (k == FRAME - 1);
            end
            e.taps = model_taps();
        end
        sb.push_back(e);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        hist.delete();
        nacc = 0;
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = dut_now();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL sb_cycle t=%0t got taps=%h done=%b fd=%b expected taps=%h done=%b fd=%b",
                             $time, a.taps, a.done, a.fdone, e.taps, e.done, e.fdone);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        exp_t a = dut_now();
        vectors++;
        if (a !== exp_t'(0)) begin
            miscompares++;
            $display("FAIL %s got taps=%h done=%b fd=%b expected all zero", name, a.taps, a.done, a.fdone);
        end
    endtask

    initial begin : driver
        #2;
        // held in reset with strobes and toggling data
        for (int i = 0; i < 4; i++) cycle(1'b1, (i % 2) ? 8'hA5 : 8'h5A);
        check_zero("reset_hold");
        rst = 1'b1;

        // continuous frame, data = k
        for (int k = 0; k < FRAME; k++) cycle(1'b1, 8'(k));

        // stalled frame: 3 idle cycles after pixels 50 and 135
        for (int k = 0; k < FRAME; k++) begin
            cycle(1'b1, 8'(k));
            if (k == 50 || k == 135) repeat (3) cycle(1'b0, 8'($urandom));
        end

        // back-to-back frame, data = 200 + k
        for (int k = 0; k < FRAME; k++) cycle(1'b1, 8'(200 + k));

        // random data with random gaps
        for (int k = 0; k < FRAME; k++) begin
            while ($urandom_range(3) == 0) cycle(1'b0, 8'($urandom));
            cycle(1'b1, 8'($urandom));
        end

        // partial frame, then asynchronous reset between edges
        for (int k = 0; k <= 140; k++) cycle(1'b1, 8'(k));
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
        rst = 1'b1;

        for (int k = 0; k < FRAME; k++) cycle(1'b1, 8'(k));
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);

        begin : drain
            int budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            @(negedge clk);
            if (sb.size() != 0) begin
                miscompares++;
                $display("FAIL drain got %0d pending expected 0", sb.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
